// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the mac_8in datapath and its sequencer.
package mac_pkg;
  localparam int MAC_LANES  = 8;
  localparam int MAC_BW     = 8;
  localparam int MAC_PSUM_W = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;
endpackage

// File: rtl/mac_dot_seq_if.sv
// Chunk-input / result-output handshake bundle of mac_dot_seq.
interface mac_dot_seq_if
  import mac_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int ACC_W = 23
);
  logic [CNT_W-1:0]            cfg_nchunk;
  logic                        in_valid;
  logic                        in_ready;
  logic [MAC_LANES*MAC_BW-1:0] in_a;
  logic [MAC_LANES*MAC_BW-1:0] in_b;
  logic                        out_valid;
  logic                        out_ready;
  logic [ACC_W-1:0]            out_data;
  logic                        busy;

  modport master (
    output cfg_nchunk, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  cfg_nchunk, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/mac_8in.sv
// 8-lane unsigned 8b x 8b multiply with combinational adder tree into a 19b partial sum.
module mac_8in
  import mac_pkg::*;
(
  input  logic [MAC_LANES*MAC_BW-1:0] a,
  input  logic [MAC_LANES*MAC_BW-1:0] b,
  output logic [MAC_PSUM_W-1:0]       psum
);
  always_comb begin
    psum = '0;
    for (int unsigned i = 0; i < MAC_LANES; i++) begin
      psum = psum + MAC_PSUM_W'(a[i*MAC_BW +: MAC_BW]) * MAC_PSUM_W'(b[i*MAC_BW +: MAC_BW]);
    end
  end
endmodule

// File: rtl/mac_dot_seq.sv
// Time-shares one mac_8in over N chunks per dot product, with a 1-deep result buffer.
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int ACC_W = 23
)(
  input  logic          clk,
  input  logic          reset,
  mac_dot_seq_if.slave  bus
);
  logic [MAC_PSUM_W-1:0] psum;
  logic [ACC_W-1:0]      psum_ext;
  logic [ACC_W-1:0]      acc_sum;
  logic [CNT_W-1:0]      cnt_inc;
  logic [CNT_W-1:0]      nl;
  logic                  accept;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_lat_q, n_lat_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  mac_8in u_mac (
    .a    (bus.in_a),
    .b    (bus.in_b),
    .psum (psum)
  );

  assign psum_ext = ACC_W'(psum);
  assign acc_sum  = acc_q + psum_ext;
  assign cnt_inc  = cnt_q + 1'b1;
  assign nl       = (bus.cfg_nchunk == '0) ? CNT_W'(1) : bus.cfg_nchunk;
  assign accept   = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = (state_q != HOLD) || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_lat_d     = n_lat_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    // Retiring a result in HOLD falls through to the first-chunk rule, so a
    // chunk accepted in the same cycle starts the next product without a bubble.
    if (state_q == HOLD && bus.out_ready) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end

    if (accept) begin
      if (state_q == ACCUM) begin
        acc_d = acc_sum;
        cnt_d = cnt_inc;
        if (cnt_inc == n_lat_q) begin
          state_d     = HOLD;
          out_data_d  = acc_sum;
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end
      end else begin
        acc_d   = psum_ext;
        cnt_d   = CNT_W'(1);
        n_lat_d = nl;
        if (nl == CNT_W'(1)) begin
          state_d     = HOLD;
          out_data_d  = psum_ext;
          out_valid_d = 1'b1;
        end else begin
          state_d = ACCUM;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_lat_q     <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_lat_q     <= n_lat_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
